// File: rtl/chain_meas_pkg.sv
// Shared definitions for the chain-measurement blocks: result status
// encoding and the measurement FSM state type.
package chain_meas_pkg;

  // Result status codes reported on status_o
  localparam logic [1:0] ST_OK        = 2'd0;  // rise and fall both seen
  localparam logic [1:0] ST_LOST      = 2'd1;  // chain swallowed the pulse
  localparam logic [1:0] ST_STUCK     = 2'd2;  // output rose but never fell
  localparam logic [1:0] ST_LINE_HIGH = 2'd3;  // output already high at start

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } meas_state_e;

endpackage

// File: rtl/chain_delay_meter_if.sv
// Request/result interface of the chain delay meter. The requester (master)
// launches a measurement; the meter (slave) returns status and timestamps.
// CNT_W/PW_W must match the parameters of the attached meter.
interface chain_delay_meter_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PW_W  = 8
);

  logic             start_i;
  logic [PW_W-1:0]  pulse_width_i;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       status_o;
  logic [CNT_W-1:0] rise_lat_o;
  logic [CNT_W-1:0] fall_lat_o;
  logic [CNT_W-1:0] out_width_o;

  modport master (
    output start_i,
    output pulse_width_i,
    input  busy_o,
    input  done_o,
    input  status_o,
    input  rise_lat_o,
    input  fall_lat_o,
    input  out_width_o
  );

  modport slave (
    input  start_i,
    input  pulse_width_i,
    output busy_o,
    output done_o,
    output status_o,
    output rise_lat_o,
    output fall_lat_o,
    output out_width_o
  );

endinterface

// File: rtl/chain_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by one
// edge-detect register. rise_o/fall_o are single-cycle pulses derived from
// the synchronized level and its previous value. SYNC_STAGES is 2..4.
module chain_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the async level in and remember the last synchronized value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/chain_delay_meter.sv
// Chain delay meter: launches one high pulse of W cycles into a delay chain,
// timestamps the synchronized rising and falling edges of the chain output
// and reports rise/fall latency, output width and a status code.
module chain_delay_meter
  import chain_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PW_W        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  chain_delay_meter_if.slave  meas_if,
  output logic                chain_in_o,
  input  logic                chain_out_i
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0]  w_q, w_d;
  logic             rise_seen_q, rise_seen_d;
  logic             chain_in_q, chain_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] rise_lat_q, rise_lat_d;
  logic [CNT_W-1:0] fall_lat_q, fall_lat_d;
  logic [CNT_W-1:0] out_width_q, out_width_d;

  logic             sync_s;
  logic             rise_s;
  logic             fall_s;
  logic [CNT_W-1:0] w_ext_s;

  chain_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (chain_out_i),
    .sync_o  (sync_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  assign w_ext_s = {{(CNT_W-PW_W){1'b0}}, w_q};

  // Next-state, launch-pulse and result computation for the sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    rise_seen_d = rise_seen_q;
    chain_in_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    status_d    = status_q;
    rise_lat_d  = rise_lat_q;
    fall_lat_d  = fall_lat_q;
    out_width_d = out_width_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (meas_if.start_i && (meas_if.pulse_width_i != '0)) begin
          // Any accepted start clears the previous results
          rise_lat_d  = '0;
          fall_lat_d  = '0;
          out_width_d = '0;
          busy_d      = 1'b1;
          if (sync_s) begin
            // Line already high: a rise could not be attributed to our pulse
            state_d  = DONE;
            status_d = ST_LINE_HIGH;
            done_d   = 1'b1;
          end else begin
            // First RUN cycle has cnt=0 with the chain input already high
            state_d     = RUN;
            status_d    = ST_OK;
            w_d         = meas_if.pulse_width_i;
            cnt_d       = '0;
            rise_seen_d = 1'b0;
            chain_in_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (cnt_q == TIMEOUT_C) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end

        // Only the first rise of the run is timestamped
        if (rise_s && !rise_seen_q) begin
          rise_lat_d  = cnt_q;
          rise_seen_d = 1'b1;
        end else begin
          rise_lat_d  = rise_lat_q;
          rise_seen_d = rise_seen_q;
        end

        if (fall_s && rise_seen_q) begin
          // Completing fall wins even on the timeout cycle
          state_d     = DONE;
          status_d    = ST_OK;
          fall_lat_d  = cnt_q;
          out_width_d = cnt_q - rise_lat_q;
          done_d      = 1'b1;
          chain_in_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d    = DONE;
          status_d   = rise_seen_d ? ST_STUCK : ST_LOST;
          done_d     = 1'b1;
          chain_in_d = 1'b0;
        end else begin
          state_d    = RUN;
          chain_in_d = (cnt_d < w_ext_s);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters, results and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      rise_seen_q <= 1'b0;
      chain_in_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      rise_lat_q  <= '0;
      fall_lat_q  <= '0;
      out_width_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      rise_seen_q <= rise_seen_d;
      chain_in_q  <= chain_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
      rise_lat_q  <= rise_lat_d;
      fall_lat_q  <= fall_lat_d;
      out_width_q <= out_width_d;
    end
  end

  assign chain_in_o          = chain_in_q;
  assign meas_if.busy_o      = busy_q;
  assign meas_if.done_o      = done_q;
  assign meas_if.status_o    = status_q;
  assign meas_if.rise_lat_o  = rise_lat_q;
  assign meas_if.fall_lat_o  = fall_lat_q;
  assign meas_if.out_width_o = out_width_q;

endmodule
